nibble_frame_assembler: RTL and testbench

Downstream consumer of the 4-bit parallel/serial shift register stage. It takes the register's 4-bit output as a valid/ready nibble stream and hunts for a header nibble. It then assembles a fixed number of data nibbles, MSB-first, into one wide word. It presents that word on a valid/ready output port with a single-entry holding buffer, and applies backpressure upstream while the word is unconsumed.

---
 rtl/nibble_frame_assembler.sv | 123 ++++++++++++
 tb/tb_nibble_frame_assembler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_frame_assembler.sv
// Hunts for a header nibble, assembles NIBBLES data nibbles MSB-first into one word,
// and holds it on a valid/ready port. Optional XOR parity check: NFA_PARITY_EN.
module nibble_frame_assembler #(
  parameter int         NIBBLES = 4,
  parameter logic [3:0] HEADER  = 4'hA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [3:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [4*NIBBLES-1:0]   out_data,
  input  logic                   out_ready,
  output logic                   par_err,
  output logic [7:0]             err_count,
  output logic                   busy
);

  localparam int         W    = 4 * NIBBLES;
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

`ifdef NFA_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`endif

  state_t         r_state;
  logic [2:0]     r_count;
  logic [W-1:0]   r_word;
  logic [W-1:0]   r_out_data;
  logic           w_accept;
  logic [W-1:0]   w_word_next;

`ifdef NFA_PARITY_EN
  logic [3:0]     r_xor;
  logic           r_par_err;
  logic [7:0]     r_err_count;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_word_next = {r_word[W-5:0], in_data};

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out_data;

`ifdef NFA_PARITY_EN
  assign par_err   = r_par_err;
  assign err_count = r_err_count;
`else
  assign par_err   = 1'b0;
  assign err_count = 8'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= 3'd0;
      r_word     <= '0;
      r_out_data <= '0;
`ifdef NFA_PARITY_EN
      r_xor       <= 4'd0;
      r_par_err   <= 1'b0;
      r_err_count <= 8'd0;
`endif
    end else begin
`ifdef NFA_PARITY_EN
      r_par_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept && (in_data == HEADER)) begin
            r_state <= COLLECT;
            r_count <= 3'd0;
            r_word  <= '0;
`ifdef NFA_PARITY_EN
            r_xor   <= 4'd0;
`endif
          end
        end
        COLLECT: begin
          // A header value here is ordinary data; no resync mid-frame.
          if (w_accept) begin
            r_word  <= w_word_next;
            r_count <= r_count + 3'd1;
`ifdef NFA_PARITY_EN
            r_xor   <= r_xor ^ in_data;
            if (r_count == LAST) r_state <= CHECK;
`else
            if (r_count == LAST) begin
              r_state    <= HOLD;
              r_out_data <= w_word_next;
            end
`endif
          end
        end
`ifdef NFA_PARITY_EN
        CHECK: begin
          if (w_accept) begin
            if (in_data == r_xor) begin
              r_state    <= HOLD;
              r_out_data <= r_word;
            end else begin
              // Bad frame: word is dropped, previous out_data is kept.
              r_state   <= IDLE;
              r_par_err <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
          end
        end
`endif
        HOLD: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_frame_assembler.sv
// Directed bench for nibble_frame_assembler (NIBBLES=4, HEADER=A); adapts to NFA_PARITY_EN.
module tb_nibble_frame_assembler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        par_err;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  nibble_frame_assembler #(.NIBBLES(4), .HEADER(4'hA)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .par_err   (par_err),
    .err_count (err_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one nibble (or a gap) for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got=%b exp=0", par_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    step(1, 4'hA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_hdr got=%b exp=1", busy); end
    step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'h4);
`ifdef NFA_PARITY_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    step(1, 4'h4);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL basic_out_data got=%h exp=1234", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_hold got=%b exp=0", in_ready); end
    step(0, 4'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got=%b exp=1", in_ready); end
  endtask

`ifdef NFA_PARITY_EN
  task automatic test_parity_err;
    step(1, 4'hA); step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'h4); step(1, 4'h5);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL perr_pulse got=%b exp=1", par_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL perr_count got=%0d exp=1", err_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL perr_no_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perr_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL perr_data_held got=%h exp=1234", out_data); end
    step(0, 4'h0);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL perr_one_cycle got=%b exp=0", par_err); end
  endtask

  task automatic test_saturation;
    int pulses;
    logic [7:0] exp_cnt;
    pulses = 0;
    for (int i = 0; i < 257; i++) begin
      step(1, 4'hA); step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'h4); step(1, 4'h5);
      if (par_err === 1'b1) pulses++;
      exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
      checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL sat_count iter=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
    end
    step(0, 4'h0);
    checks++; if (pulses != 257) begin errors++; $display("FAIL sat_pulses got=%0d exp=257", pulses); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", err_count); end
  endtask
`endif

  task automatic test_hunt;
    step(1, 4'h3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hunt_discard3 got=%b exp=0", busy); end
    step(1, 4'h7);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hunt_discard7 got=%b exp=0", busy); end
    step(1, 4'hA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hunt_hdr got=%b exp=1", busy); end
    step(1, 4'hF); step(1, 4'h0); step(1, 4'h0); step(1, 4'h1);
`ifdef NFA_PARITY_EN
    step(1, 4'hE);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hunt_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'hF001) begin errors++; $display("FAIL hunt_data got=%h exp=F001", out_data); end
    step(0, 4'h0);
  endtask

  task automatic test_header_data_gaps;
    step(1, 4'hA); step(1, 4'hA);
    step(0, 4'h0); step(0, 4'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b exp=1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got=%b exp=0", out_valid); end
    step(1, 4'hA); step(1, 4'hA); step(1, 4'hA);
`ifdef NFA_PARITY_EN
    step(1, 4'h0);
`endif
    checks++; if (out_data !== 16'hAAAA) begin errors++; $display("FAIL gap_data got=%h exp=AAAA", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid got=%b exp=1", out_valid); end
    step(0, 4'h0);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    step(1, 4'hA); step(1, 4'h9); step(1, 4'h8); step(1, 4'h7); step(1, 4'h6);
`ifdef NFA_PARITY_EN
    step(1, 4'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== 16'h9876) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=9876", i, out_data); end
      step(1, 4'hA);
    end
    out_ready = 1'b1;
    step(1, 4'hA);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept_in_hold got=%b exp=0", busy); end
    step(1, 4'hA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_hdr got=%b exp=1", busy); end
  endtask

  task automatic test_reset_mid_frame;
    step(1, 4'h1); step(1, 4'h2);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data got=%h exp=0000", out_data); end
    reset = 1'b0;
    step(1, 4'hA); step(1, 4'h5); step(1, 4'h6); step(1, 4'h7);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early got=%b exp=0", out_valid); end
    step(1, 4'h8);
`ifdef NFA_PARITY_EN
    step(1, 4'hC);
`endif
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'h5678) begin errors++; $display("FAIL rst_mid_out got=%h exp=5678", out_data); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_errcnt got=%0d exp=0", err_count); end
    step(0, 4'h0);
  endtask

  initial begin
    test_reset;
    test_basic;
`ifdef NFA_PARITY_EN
    test_parity_err;
`endif
    test_hunt;
    test_header_data_gaps;
    test_backpressure;
    test_reset_mid_frame;
`ifdef NFA_PARITY_EN
    test_saturation;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
